// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register and register-file write-back mux.
// Selects ALU result, aligned/extended load data, or link address (PC+4),
// drives the register-file write port, and flags misaligned loads.
// Optional build macro: WB_RETIRE_COUNT_EN adds the o_retired instruction counter.
module writeback_stage #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_ADDR = 5
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic               i_regWrite,
    input  logic               i_mem2Reg,
    input  logic               i_link,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic [NB_DATA-1:0] i_mem_data,
    input  logic [NB_DATA-1:0] i_pcounter4,
    input  logic [1:0]         i_load_size,
    input  logic               i_load_unsigned,
    input  logic [NB_ADDR-1:0] i_wr_addr,
    input  logic               i_stall,
    input  logic               i_flush,
    output logic               o_we_wb,
    output logic [NB_ADDR-1:0] o_wr_addr,
    output logic [NB_DATA-1:0] o_wr_data,
`ifdef WB_RETIRE_COUNT_EN
    output logic [NB_DATA-1:0] o_retired,
`endif
    output logic               o_misaligned
);

    localparam int unsigned NB_BYTE = 8;
    localparam int unsigned NB_HALF = 16;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    logic [1:0]         w_offset;
    logic [NB_BYTE-1:0] w_byte;
    logic [NB_HALF-1:0] w_half;
    logic [NB_DATA-1:0] w_load_ext;
    logic               w_mis_cond;
    logic               w_misaligned;
    logic [NB_DATA-1:0] w_wr_data;
    logic               w_we;

    logic               r_valid;
    logic               r_we;
    logic               r_misaligned;
    logic [NB_ADDR-1:0] r_wr_addr;
    logic [NB_DATA-1:0] r_wr_data;

    assign w_offset = i_alu_result[1:0];

    // Little-endian byte and halfword lane selection from the raw memory word
    always_comb begin
        w_byte = i_mem_data[NB_BYTE-1:0];
        case (w_offset)
            2'd1:    w_byte = i_mem_data[2*NB_BYTE-1:NB_BYTE];
            2'd2:    w_byte = i_mem_data[3*NB_BYTE-1:2*NB_BYTE];
            2'd3:    w_byte = i_mem_data[4*NB_BYTE-1:3*NB_BYTE];
            default: w_byte = i_mem_data[NB_BYTE-1:0];
        endcase
        w_half = w_offset[1] ? i_mem_data[2*NB_HALF-1:NB_HALF] : i_mem_data[NB_HALF-1:0];
    end

    // Sign/zero extension by access size; reserved size behaves as word
    always_comb begin
        w_load_ext = i_mem_data;
        case (i_load_size)
            SIZE_BYTE: w_load_ext = i_load_unsigned ? NB_DATA'(w_byte)
                                  : {{(NB_DATA-NB_BYTE){w_byte[NB_BYTE-1]}}, w_byte};
            SIZE_HALF: w_load_ext = i_load_unsigned ? NB_DATA'(w_half)
                                  : {{(NB_DATA-NB_HALF){w_half[NB_HALF-1]}}, w_half};
            default:   w_load_ext = i_mem_data;
        endcase
    end

    // Alignment rule: halves need an even offset, words need offset zero
    always_comb begin
        w_mis_cond = 1'b0;
        case (i_load_size)
            SIZE_BYTE: w_mis_cond = 1'b0;
            SIZE_HALF: w_mis_cond = w_offset[0];
            default:   w_mis_cond = (w_offset != 2'd0);
        endcase
    end

    // Write-back value and enable; link wins over load, load over ALU
    always_comb begin
        w_misaligned = i_valid & i_mem2Reg & ~i_link & w_mis_cond;
        if (i_link) begin
            w_wr_data = i_pcounter4;
        end else if (i_mem2Reg) begin
            w_wr_data = w_mis_cond ? i_mem_data : w_load_ext;
        end else begin
            w_wr_data = i_alu_result;
        end
        w_we = i_valid & i_regWrite & ~w_misaligned & (i_wr_addr != '0);
    end

    // MEM/WB register: reset > flush > stall > load; held cycles never re-write or re-flag
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_valid      <= 1'b0;
            r_we         <= 1'b0;
            r_misaligned <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
        end else if (i_flush) begin
            r_valid      <= 1'b0;
            r_we         <= 1'b0;
            r_misaligned <= 1'b0;
        end else if (i_stall) begin
            r_we         <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_valid      <= i_valid;
            r_we         <= w_we;
            r_misaligned <= w_misaligned;
            r_wr_addr    <= i_wr_addr;
            r_wr_data    <= w_wr_data;
        end
    end

`ifdef WB_RETIRE_COUNT_EN
    logic [NB_DATA-1:0] r_retired;

    // Count real instructions entering the stage; wraps naturally
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_retired <= '0;
        end else if (!i_flush && !i_stall && i_valid) begin
            r_retired <= r_retired + NB_DATA'(1);
        end
    end

    assign o_retired = r_retired;
`endif

    assign o_we_wb      = r_we;
    assign o_misaligned = r_misaligned;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;

    // r_valid records stage occupancy; outputs already carry its effect
    logic w_unused;
    assign w_unused = r_valid;

endmodule

// File: tb/tb_writeback_stage.sv
// Testbench for writeback_stage: directed cases followed by randomized traffic,
// compared against a behavioural model of the write-back rules.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid, i_regWrite, i_mem2Reg, i_link;
    logic [31:0] i_alu_result, i_mem_data, i_pcounter4;
    logic [1:0]  i_load_size;
    logic        i_load_unsigned;
    logic [4:0]  i_wr_addr;
    logic        i_stall, i_flush;
    logic        o_we_wb;
    logic [4:0]  o_wr_addr;
    logic [31:0] o_wr_data;
    logic        o_misaligned;
`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] o_retired;
`endif

    int checks = 0;
    int errors = 0;

    // expected state
    logic        e_we, e_mis, e_dc;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_retired;

    always #5 clk = ~clk;

    writeback_stage #(.NB_DATA(32), .NB_ADDR(5)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_regWrite(i_regWrite),
        .i_mem2Reg(i_mem2Reg), .i_link(i_link), .i_alu_result(i_alu_result),
        .i_mem_data(i_mem_data), .i_pcounter4(i_pcounter4), .i_load_size(i_load_size),
        .i_load_unsigned(i_load_unsigned), .i_wr_addr(i_wr_addr), .i_stall(i_stall),
        .i_flush(i_flush), .o_we_wb(o_we_wb), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
`ifdef WB_RETIRE_COUNT_EN
        .o_retired(o_retired),
`endif
        .o_misaligned(o_misaligned)
    );

    function automatic logic ref_mis(input logic [1:0] size, input int unsigned off);
        if (size == 2'd0) return 1'b0;
        if (size == 2'd1) return (off % 2) == 1;
        return off != 0;
    endfunction

    // Load value from shifts and masks on the raw word
    function automatic logic [31:0] ref_load(input logic [31:0] word, input int unsigned off,
                                             input logic [1:0] size, input logic uns);
        int unsigned w, v;
        w = word;
        if (size == 2'd0) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (!uns && v >= 128) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (w >> (8 * off)) & 32'hFFFF;
            if (!uns && v >= 32768) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return 32'(v);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_instr(input logic v, input logic rw, input logic m2r, input logic lnk,
                             input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
                             input logic [1:0] size, input logic uns, input logic [4:0] addr);
        i_valid = v; i_regWrite = rw; i_mem2Reg = m2r; i_link = lnk;
        i_alu_result = alu; i_mem_data = mem; i_pcounter4 = pc4;
        i_load_size = size; i_load_unsigned = uns; i_wr_addr = addr;
    endtask

    // Advance model and DUT one edge, then compare all observable outputs
    task automatic step();
        int unsigned off;
        logic mis;
        off = int'(i_alu_result[1:0]);
        if (!i_rst_n) begin
            e_we = 0; e_mis = 0; e_addr = 0; e_data = 0; e_retired = 0; e_dc = 0;
        end else if (i_flush) begin
            e_we = 0; e_mis = 0; e_dc = 1;
        end else if (i_stall) begin
            e_we = 0; e_mis = 0;
        end else begin
            mis = i_valid && i_mem2Reg && !i_link && ref_mis(i_load_size, off);
            e_addr = i_wr_addr;
            if (i_link) e_data = i_pcounter4;
            else if (i_mem2Reg)
                e_data = ref_mis(i_load_size, off) ? i_mem_data
                         : ref_load(i_mem_data, off, i_load_size, i_load_unsigned);
            else e_data = i_alu_result;
            e_we = i_valid && i_regWrite && !mis && (i_wr_addr != 5'd0);
            e_mis = mis;
            e_dc = 0;
            if (i_valid) e_retired = e_retired + 32'd1;
        end
        @(posedge clk);
        #1;
        check("we", 32'(o_we_wb), 32'(e_we));
        check("misaligned", 32'(o_misaligned), 32'(e_mis));
        if (!e_dc) begin
            check("wr_addr", 32'(o_wr_addr), 32'(e_addr));
            check("wr_data", o_wr_data, e_data);
        end
`ifdef WB_RETIRE_COUNT_EN
        check("retired", o_retired, e_retired);
`endif
    endtask

    initial begin
        e_we = 0; e_mis = 0; e_dc = 0; e_addr = 0; e_data = 0; e_retired = 0;
        i_rst_n = 0; i_stall = 0; i_flush = 0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 2'd2, 0, 0);
        #2;
        step();
        check("reset_data", o_wr_data, 32'h0);
        step();
        i_rst_n = 1;

        // ALU path
        set_instr(1, 1, 0, 0, 32'h0000_1234, 0, 0, 2'd2, 0, 5'd5);
        step();
        check("alu_we", 32'(o_we_wb), 32'd1);
        check("alu_data", o_wr_data, 32'h0000_1234);

        // load extension
        set_instr(1, 1, 1, 0, 32'h3, 32'h80FF_7F01, 0, 2'd0, 0, 5'd7);
        step(); check("lb_off3", o_wr_data, 32'hFFFF_FF80);
        set_instr(1, 1, 1, 0, 32'h3, 32'h80FF_7F01, 0, 2'd0, 1, 5'd7);
        step(); check("lbu_off3", o_wr_data, 32'h0000_0080);
        set_instr(1, 1, 1, 0, 32'h2, 32'h80FF_7F01, 0, 2'd1, 0, 5'd7);
        step(); check("lh_off2", o_wr_data, 32'hFFFF_80FF);
        set_instr(1, 1, 1, 0, 32'h0, 32'h80FF_7F01, 0, 2'd1, 1, 5'd7);
        step(); check("lhu_off0", o_wr_data, 32'h0000_7F01);

        // misaligned word and half, each a single-cycle pulse
        set_instr(1, 1, 1, 0, 32'h6, 32'h1122_3344, 0, 2'd2, 0, 5'd8);
        step(); check("lw_mis", 32'(o_misaligned), 32'd1);
        set_instr(0, 0, 0, 0, 0, 0, 0, 2'd2, 0, 0);
        step();
        set_instr(1, 1, 1, 0, 32'h1, 32'h1122_3344, 0, 2'd1, 0, 5'd8);
        step(); check("lh_mis_we", 32'(o_we_wb), 32'd0);

        // link and $zero
        set_instr(1, 1, 1, 1, 32'h3, 32'hDEAD_BEEF, 32'h40, 2'd2, 0, 5'd31);
        step(); check("link_data", o_wr_data, 32'h40);
        set_instr(1, 1, 1, 1, 32'h3, 32'hDEAD_BEEF, 32'h40, 2'd2, 0, 5'd0);
        step(); check("zero_we", 32'(o_we_wb), 32'd0);

        // stall holds contents but writes only once
        set_instr(1, 1, 0, 0, 32'h0000_AAAA, 0, 0, 2'd2, 0, 5'd9);
        step();
        set_instr(1, 1, 0, 0, 32'h5555_0000, 0, 0, 2'd2, 0, 5'd10);
        i_stall = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_hold", o_wr_data, 32'h0000_AAAA);
        end
        i_flush = 1;
        step();
        i_flush = 0;
        i_rst_n = 0;
        step();
        i_rst_n = 1; i_stall = 0;
        step();

`ifdef WB_RETIRE_COUNT_EN
        // counter: 4 valid, 1 bubble, 1 stalled cycle
        i_rst_n = 0; step(); i_rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            set_instr(1, 0, 0, 0, 32'(k), 0, 0, 2'd2, 0, 5'd3);
            step();
        end
        set_instr(0, 0, 0, 0, 0, 0, 0, 2'd2, 0, 0);
        step();
        set_instr(1, 1, 0, 0, 32'h77, 0, 0, 2'd2, 0, 5'd3);
        i_stall = 1; step(); i_stall = 0;
        check("retired_4", o_retired, 32'd4);
        force dut.r_retired = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired;
        e_retired = 32'hFFFF_FFFF;
        step(); check("retired_wrap", o_retired, 32'd0);
        step(); check("retired_after_wrap", o_retired, 32'd1);
`endif

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            set_instr(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 5) == 0),
                      $urandom, $urandom, $urandom, 2'($urandom), 1'($urandom), 5'($urandom));
            i_stall = ($urandom_range(0, 4) == 0);
            i_flush = ($urandom_range(0, 9) == 0);
            i_rst_n = ($urandom_range(0, 49) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final MIPS pipeline stage: the writer side of the register-file port that instruction_decode reads.
- Registers MEM-stage results into the MEM/WB pipeline register and selects the write-back value: ALU result, aligned/extended load data, or link address PC+4.
- Drives the register-file write port (we/addr/data) used by the decode stage.
- Flags misaligned loads and suppresses their write.

Parameters:
- NB_DATA, 32, datapath width
- NB_ADDR, 5, register address width

Ports:
- clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_valid  in  1  MEM stage holds a real instruction
- i_regWrite  in  1  instruction writes a register
- i_mem2Reg  in  1  1 = load data, 0 = ALU result
- i_link  in  1  1 = write i_pcounter4 (jal/jalr); overrides i_mem2Reg
- i_alu_result  in  NB_DATA  ALU result; bits [1:0] are the load byte offset
- i_mem_data  in  NB_DATA  raw aligned word from data memory
- i_pcounter4  in  NB_DATA  PC+4 of the instruction
- i_load_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- i_load_unsigned  in  1  zero-extend (lbu/lhu) instead of sign-extend
- i_wr_addr  in  NB_ADDR  destination register
- i_stall  in  1  hold the MEM/WB register
- i_flush  in  1  invalidate the MEM/WB register
- o_we_wb  out  1  register-file write enable
- o_wr_addr  out  NB_ADDR  register-file write address
- o_wr_data  out  NB_DATA  register-file write data
- o_misaligned  out  1  one-cycle pulse: misaligned load retired

Behaviour:
- Reset (i_rst_n=0 at posedge clk): valid bit, o_we_wb, o_misaligned = 0; o_wr_addr = 0; o_wr_data = 0. Reset overrides stall and flush.
- Latency: inputs sampled at edge N appear on outputs after edge N; outputs are registered.
- Load extraction, little-endian, offset = i_alu_result[1:0]:
  - byte: selects byte[offset].
  - half: offset 0 selects [15:0]; offset 2 selects [31:16].
  - word: requires offset 0.
  - Sign- or zero-extend to NB_DATA per i_load_unsigned.
- Misaligned: half with offset 1 or 3; word with offset != 0. Applies only when i_mem2Reg=1 and i_link=0. Result: o_misaligned=1 for one cycle, o_we_wb=0, o_wr_data still updates with the unmasked word.
- Write enable: o_we_wb = valid & regWrite & !misaligned & (wr_addr != 0). A write to $zero is never asserted.
- Data select priority: link > mem2Reg > ALU result.
- Edge priority: reset > flush > stall > load.
  - Flush: valid=0, o_we_wb=0, o_misaligned=0; other fields don't care.
  - Stall: all registered fields hold, but o_we_wb and o_misaligned are forced 0 on held cycles. Each instruction writes and flags exactly once.
  - After a stall releases, new inputs load normally.
- i_valid=0 behaves as a bubble: o_we_wb=0.
- Back-to-back writes to the same register: each cycle writes its own value; no merging.

Optional Feature:
- Macro WB_RETIRE_COUNT_EN.
- When defined: adds output o_retired (NB_DATA). It increments by 1 on every cycle where a valid, non-flushed, non-stalled instruction is loaded into the stage, whether or not it writes a register. It wraps from 2^NB_DATA-1 to 0, is cleared by reset, and is not incremented by bubbles.
- When not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- ALU path: valid=1, regWrite=1, mem2Reg=0, alu=0x0000_1234, addr=5 -> next cycle we=1, addr=5, data=0x0000_1234.
- Load extension: mem_data=0x80FF_7F01. lb offset 3 -> data=0xFFFF_FF80. lbu offset 3 -> 0x0000_0080. lh offset 2 -> 0xFFFF_80FF. lhu offset 0 -> 0x0000_7F01.
- Misaligned: lw with alu=0x0000_0006 -> o_misaligned=1 for one cycle, we=0. lh offset 1 behaves the same.
- Link and $zero: link=1, mem2Reg=1, pcounter4=0x40, addr=31 -> data=0x40, we=1. Same instruction with addr=0 -> we=0.
- Stall/flush: load an instruction, then assert stall for 3 cycles -> we=1 only on the first cycle, addr/data held. Assert stall and flush together -> we=0 and the stage is invalid. Reset during a stall -> all outputs 0.
- Counter (WB_RETIRE_COUNT_EN): 4 valid instructions, 1 bubble, 1 stalled cycle -> o_retired=4. Preset near max, then retire 2 -> counter wraps to 0, then 1.
